stage_addr_gen: RTL
===================

# stage_addr_gen

Upstream address and read-enable sequencer for the 128-entry, 4-read-port stage data RAM of the mixed-radix NTT. Each issue cycle it drives four coefficient addresses, one butterfly group, plus the RAM enables SEN/SREN. It walks three radix-4 stages and one final radix-2 stage over 128 coefficients. Between stages it inserts a fixed drain gap so downstream write-back can complete before the next stage reads.

## Interface
- GAP, 8: idle cycles between consecutive stages (SREN=0, SEN=1); legal range 1..255.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a 4-stage pass; sampled only in IDLE.
- hold  in  1  downstream stall; freezes issue during READ.
- SEN  out  1  RAM enable; 1 in READ and DRAIN.
- SREN  out  1  RAM read strobe; 1 only in an issue cycle.
- A0, A1, A2, A3  out  7 each  butterfly group addresses.
- stage  out  2  current stage 0..3.
- radix2  out  1  1 while stage==3, where (A0,A1) and (A2,A3) are two radix-2 pairs.
- stage_last  out  1  1 on the issue cycle of group 31 of any stage.
- busy  out  1  1 in READ or DRAIN.
- done  out  1  one-cycle pulse after the final issue.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- Group counter b (5 bits, 0..31). Stage stride s = 32, 8, 2, 1 for stages 0..3.
- Address arithmetic: g = b / s; j = b mod s; base = g·4s + j; Ak = base + k·s for k=0..3.
  - Computed in 7-bit unsigned; no overflow is possible (max 127).
  - Stage 3 reduces to Ak = 4b + k.
- IDLE -> READ: on start.
  - stage=0, b=0.
  - start while not IDLE is ignored.
- READ, hold=0: issue cycle.
  - SREN=1, A0..A3 valid, b increments after the cycle.
- READ, hold=1:
  - SREN=0; b, stage and A0..A3 hold their values.
  - SEN stays 1, so the RAM keeps Q.
- READ, issue with b=31:
  - stage_last=1.
  - If stage<3: go to DRAIN, with gap counter loaded to GAP.
  - If stage==3: go to DONE.
- DRAIN:
  - SREN=0; the counter decrements each cycle and hold is ignored.
  - After GAP cycles: go to READ, stage+1, b=0.
- DONE:
  - done=1, busy=0, SEN=0, SREN=0 for one cycle.
  - Then IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Reset values: SEN=0, SREN=0, A0..A3=0, stage=0, radix2=0, stage_last=0, busy=0, done=0; state IDLE.
- rst mid-pass: at the next rising edge, state goes to IDLE and outputs take their reset values; the pass is abandoned. rst has priority over start and hold.
- Start latency: start high at edge 0 -> first issue (stage 0, b=0) visible in cycle 1.
- RAM data for an issue cycle appear on Q0..Q3 one cycle later. The downstream consumer qualifies Q with SREN delayed by one cycle.
- Throughput: 1 group per cycle when hold=0.
- Pass length with hold never asserted:
  - 128 issue cycles + 3·GAP drain cycles.
  - GAP=8: issues in cycles 1–32, 41–72, 81–112, 121–152; drains in cycles 33–40, 73–80, 113–120; done in cycle 153.
- Each hold cycle in READ extends the pass by exactly one cycle.
- start asserted in the same cycle as done: ignored, because the state is DONE, not IDLE. The earliest accepted restart is in the first IDLE cycle.

## Test plan
- Reset then idle: rst for 2 cycles, start=0 -> all outputs 0, SEN=0, busy=0 indefinitely.
- Full pass, GAP=8, hold=0, start at edge 0. Required response:
  - Cycle 1: A=0,32,64,96.
  - Cycle 32: A=31,63,95,127 with stage_last=1.
  - Cycle 50 (stage 1, b=9): A=33,41,49,57.
  - Cycle 86 (stage 2, b=5): A=17,19,21,23.
  - Cycle 152: A=124,125,126,127 with radix2=1.
  - done=1 only in cycle 153.
  - Exactly 128 SREN cycles.
- Coverage check: across each stage, the union of A0..A3 is exactly {0..127}, with each address appearing once.
- Hold: assert hold during stage 0, cycles 5–7.
  - Cycles 5–7: SREN=0, SEN=1, A frozen at 4,36,68,100.
  - Cycle 8: issue resumes at 4,36,68,100.
  - done moves to cycle 156.
- Reset mid-pass: rst at cycle 60 -> cycle 61 shows all outputs 0 and IDLE. A new start gives a fresh pass from stage 0, b=0.
- start during busy and start coincident with done: no effect on sequence or timing. A start one cycle after done launches a new pass.

Source files
------------

// File: rtl/stage_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : stage_addr_gen
// Brief   : Address / read-enable sequencer for the 4-port NTT stage RAM.
//           Three radix-4 stages plus one radix-2 stage over 128 points,
//           with a fixed drain gap between stages.
// Revision: 1.0
// ============================================================================
module stage_addr_gen #(
  parameter int unsigned GAP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  output logic       SEN,
  output logic       SREN,
  output logic [6:0] A0,
  output logic [6:0] A1,
  output logic [6:0] A2,
  output logic [6:0] A3,
  output logic [1:0] stage,
  output logic       radix2,
  output logic       stage_last,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] C_GAP        = 8'(GAP);
  localparam logic [4:0] C_LAST_GRP   = 5'd31;
  localparam logic [1:0] C_LAST_STAGE = 2'd3;

  state_t          state_q, state_d;
  logic [4:0]      b_q, b_d;
  logic [1:0]      stage_q, stage_d;
  logic [7:0]      gap_q, gap_d;
  logic            sen_q, sen_d;
  logic            sren_q, sren_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            radix2_q, radix2_d;
  logic [3:0][6:0] a_q, a_d;
  logic            addr_en;

  // Stride is 2^lg with lg = 5,3,1,0; base = (b/s)*4s + (b mod s).
  function automatic logic [6:0] grp_addr(input logic [1:0] stg,
                                          input logic [4:0] b,
                                          input logic [1:0] k);
    logic [2:0] lg;
    logic [6:0] b7, s, j, g, base;
    case (stg)
      2'd0:    lg = 3'd5;
      2'd1:    lg = 3'd3;
      2'd2:    lg = 3'd1;
      default: lg = 3'd0;
    endcase
    b7   = {2'b00, b};
    s    = 7'd1 << lg;
    j    = b7 & (s - 7'd1);
    g    = b7 >> lg;
    base = (g << (lg + 3'd2)) + j;
    return base + ({5'b00000, k} << lg);
  endfunction

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    stage_d = stage_q;
    gap_d   = gap_q;
    sen_d   = 1'b0;
    sren_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          b_d     = '0;
          stage_d = '0;
          sen_d   = 1'b1;
          busy_d  = 1'b1;
          sren_d  = ~hold;
        end
      end
      READ: begin
        sen_d  = 1'b1;
        busy_d = 1'b1;
        // The current cycle's group advances only if it was actually issued.
        if (sren_q) begin
          if (b_q == C_LAST_GRP) begin
            if (stage_q == C_LAST_STAGE) begin
              state_d = DONE;
              sen_d   = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = DRAIN;
              gap_d   = C_GAP;
            end
          end else begin
            b_d    = b_q + 5'd1;
            sren_d = ~hold;
          end
        end else begin
          sren_d = ~hold;
        end
      end
      DRAIN: begin
        sen_d  = 1'b1;
        busy_d = 1'b1;
        if (gap_q == 8'd1) begin
          state_d = READ;
          stage_d = stage_q + 2'd1;
          b_d     = '0;
          sren_d  = ~hold;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        stage_d = '0;
        b_d     = '0;
      end
    endcase

    last_d   = sren_d & (b_d == C_LAST_GRP);
    radix2_d = (stage_d == C_LAST_STAGE);
    addr_en  = (state_d == READ) || (state_d == DRAIN);
    for (int k = 0; k < 4; k++) begin
      a_d[k] = addr_en ? grp_addr(stage_d, b_d, 2'(k)) : 7'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      b_q      <= '0;
      stage_q  <= '0;
      gap_q    <= '0;
      sen_q    <= 1'b0;
      sren_q   <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      radix2_q <= 1'b0;
      a_q      <= '0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      stage_q  <= stage_d;
      gap_q    <= gap_d;
      sen_q    <= sen_d;
      sren_q   <= sren_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      radix2_q <= radix2_d;
      a_q      <= a_d;
    end
  end

  assign SEN        = sen_q;
  assign SREN       = sren_q;
  assign A0         = a_q[0];
  assign A1         = a_q[1];
  assign A2         = a_q[2];
  assign A3         = a_q[3];
  assign stage      = stage_q;
  assign radix2     = radix2_q;
  assign stage_last = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire
